// File: rtl/hi_fanout_bcast_sched_if.sv
// Request-side handshake bundle for the broadcast scheduler: per-requester valid/data in, one-hot ready out.
interface hi_fanout_bcast_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/hi_fanout_bcast_sched.sv
// Round-robin arbitrated broadcast register whose load flops are enabled a group at a time,
// so the heavily loaded net never switches all of its captures in one cycle.
module hi_fanout_bcast_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned NUM_LOADS  = 35,
  parameter int unsigned GROUP_SIZE = 8
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  hi_fanout_bcast_sched_if.slave        req,
  input  logic                          hold,
  output logic [WIDTH-1:0]              bcast_q,
  output logic [NUM_LOADS-1:0]          load_en,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_id,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_GROUPS = (NUM_LOADS + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int unsigned GW         = $clog2(NUM_GROUPS + 1);

  typedef enum logic [1:0] {IDLE, SPREAD, DONE} state_t;

  state_t               state, state_d;
  logic [GW-1:0]        nxt_grp, nxt_grp_d;   // next group to enable (frozen while held)
  logic [IW-1:0]        rr_ptr, rr_d;
  logic [NUM_LOADS-1:0] load_en_d;
  logic [WIDTH-1:0]     bcast_d;
  logic [IW-1:0]        gnt_d;
  logic                 busy_d, done_d;

  logic                 found;
  logic [IW-1:0]        win;
  logic [WIDTH-1:0]     win_data;
  logic [NUM_REQ-1:0]   onehot;

  // Bits of group g, with the tail of the last group clipped at NUM_LOADS.
  function automatic logic [NUM_LOADS-1:0] grp_mask(input logic [GW-1:0] g);
    logic [NUM_LOADS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LOADS; i++)
      if (GW'(i / GROUP_SIZE) == g) m[i] = 1'b1;
    return m;
  endfunction

  // Round-robin pick: scan ports above rr_ptr first, then wrap to ports at or below it.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    onehot   = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (!found && req.req_valid[j] && (IW'(j) > rr_ptr)) begin
        found     = 1'b1;
        win       = IW'(j);
        win_data  = req.req_data[j*WIDTH +: WIDTH];
        onehot[j] = 1'b1;
      end
    for (int j = 0; j < NUM_REQ; j++)
      if (!found && req.req_valid[j] && (IW'(j) <= rr_ptr)) begin
        found     = 1'b1;
        win       = IW'(j);
        win_data  = req.req_data[j*WIDTH +: WIDTH];
        onehot[j] = 1'b1;
      end
  end

  assign req.req_ready = (state == IDLE && rst_n) ? onehot : '0;

  always_comb begin
    state_d   = state;
    nxt_grp_d = nxt_grp;
    rr_d      = rr_ptr;
    load_en_d = '0;
    bcast_d   = bcast_q;
    gnt_d     = gnt_id;
    busy_d    = busy;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          bcast_d   = win_data;
          gnt_d     = win;
          rr_d      = win;
          load_en_d = grp_mask(GW'(0));
          nxt_grp_d = GW'(1);
          busy_d    = 1'b1;
          state_d   = SPREAD;
        end
      end
      SPREAD: begin
        if (!hold) begin
          if (nxt_grp == GW'(NUM_GROUPS)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            load_en_d = grp_mask(nxt_grp);
            nxt_grp_d = nxt_grp + GW'(1);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nxt_grp <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
      load_en <= '0;
      bcast_q <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      nxt_grp <= nxt_grp_d;
      rr_ptr  <= rr_d;
      load_en <= load_en_d;
      bcast_q <= bcast_d;
      gnt_id  <= gnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_hi_fanout_bcast_sched.sv
// Directed bench for hi_fanout_bcast_sched: reset, group walk, round-robin, hold and mid-spread reset.
module tb_hi_fanout_bcast_sched;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [0:0]  bcast_q;
  logic [34:0] load_en;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  hi_fanout_bcast_sched_if #(.NUM_REQ(4), .WIDTH(1)) rq ();

  hi_fanout_bcast_sched #(
    .NUM_REQ(4), .WIDTH(1), .NUM_LOADS(35), .GROUP_SIZE(8)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .req(rq.slave), .hold(hold),
    .bcast_q(bcast_q), .load_en(load_en), .gnt_id(gnt_id),
    .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 20) begin
      step;
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [3:0] d;
    int         n;
    int         e;

    // Reset with random inputs
    rst_n        = 1'b0;
    hold         = 1'($urandom);
    rq.req_valid = 4'($urandom) | 4'b0001;
    rq.req_data  = 4'($urandom);
    step;
    step;
    check("rst_ready", 64'(rq.req_ready), 64'd0);
    check("rst_load_en", 64'(load_en), 64'd0);
    check("rst_bcast", 64'(bcast_q), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'(gnt_id), 64'd0);

    @(negedge clk1);
    rst_n        = 1'b1;
    hold         = 1'b0;
    rq.req_valid = 4'b0001;
    rq.req_data  = 4'b0001;
    #1;
    check("rel_ready", 64'(rq.req_ready), 64'h1);

    // Group walk, 35 loads in groups of 8
    step;
    rq.req_valid = 4'b0000;
    check("t1_bcast", 64'(bcast_q), 64'd1);
    check("t1_gnt", 64'(gnt_id), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    check("grp0", 64'(load_en), 64'hFF);
    step; check("grp1", 64'(load_en), 64'hFF00);
    step; check("grp2", 64'(load_en), 64'hFF_0000);
    step; check("grp3", 64'(load_en), 64'hFF00_0000);
    step; check("grp4", 64'(load_en), 64'h7_0000_0000);
    check("grp4_nodone", 64'(done), 64'd0);
    rq.req_valid = 4'b0010;
    rq.req_data  = 4'b0001;
    step;
    check("t6_done", 64'(done), 64'd1);
    check("t6_load_en", 64'(load_en), 64'd0);
    check("t6_ready", 64'(rq.req_ready), 64'd0);
    check("t6_busy", 64'(busy), 64'd1);
    step;
    check("t7_done", 64'(done), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_ready", 64'(rq.req_ready), 64'h2);
    step;
    rq.req_valid = 4'b0000;
    check("p1_gnt", 64'(gnt_id), 64'd1);
    check("p1_bcast", 64'(bcast_q), 64'd0);
    check("p1_stable", 64'(bcast_q), 64'd0);
    wait_idle;

    // Round-robin from a fresh reset with all ports requesting
    rst_n = 1'b0;
    step;
    @(negedge clk1);
    rst_n        = 1'b1;
    d            = 4'b0101;
    rq.req_valid = 4'b1111;
    rq.req_data  = d;
    #1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      n = 0;
      while (rq.req_ready == 4'b0000 && n < 20) begin
        step;
        n++;
      end
      check("rr_ready", 64'(rq.req_ready), 64'(4'b0001 << e));
      step;
      check("rr_gnt", 64'(gnt_id), 64'(e));
      check("rr_bcast", 64'(bcast_q), 64'(d[e]));
      wait_idle;
    end
    rq.req_valid = 4'b0000;

    // Hold for 3 cycles while group 2 is enabled
    rq.req_valid = 4'b0100;
    #1;
    check("h_ready", 64'(rq.req_ready), 64'h4);
    step;
    rq.req_valid = 4'b0000;
    check("h_grp0", 64'(load_en), 64'hFF);
    step; check("h_grp1", 64'(load_en), 64'hFF00);
    step; check("h_grp2", 64'(load_en), 64'hFF_0000);
    hold = 1'b1;
    step; check("h_off1", 64'(load_en), 64'd0);
    check("h_busy", 64'(busy), 64'd1);
    step; check("h_off2", 64'(load_en), 64'd0);
    step; check("h_off3", 64'(load_en), 64'd0);
    check("h_bcast", 64'(bcast_q), 64'd1);
    hold = 1'b0;
    step; check("h_grp3", 64'(load_en), 64'hFF00_0000);
    step; check("h_grp4", 64'(load_en), 64'h7_0000_0000);
    check("h_nodone", 64'(done), 64'd0);
    step; check("h_done", 64'(done), 64'd1);
    step; check("h_idle", 64'(busy), 64'd0);

    // Hold is ignored at the grant; then reset while group 1 is enabled
    hold         = 1'b1;
    rq.req_valid = 4'b0001;
    #1;
    check("hi_ready", 64'(rq.req_ready), 64'h1);
    step;
    hold         = 1'b0;
    rq.req_valid = 4'b0000;
    check("hi_grp0", 64'(load_en), 64'hFF);
    check("hi_bcast", 64'(bcast_q), 64'd1);
    step; check("mr_grp1", 64'(load_en), 64'hFF00);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_load_en", 64'(load_en), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_bcast", 64'(bcast_q), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step;
      check("mr_nodone", 64'(done), 64'd0);
    end
    @(negedge clk1);
    rst_n        = 1'b1;
    rq.req_valid = 4'b0010;
    #1;
    check("mr_ready", 64'(rq.req_ready), 64'h2);
    step;
    rq.req_valid = 4'b0000;
    check("mr_gnt", 64'(gnt_id), 64'd1);
    check("mr_busy2", 64'(busy), 64'd1);
    wait_idle;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
